// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined chunked adder/subtractor; NZCV flags port enabled by ADDER_FLAGS_EN
module adder_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef ADDER_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int CHUNK = WIDTH / STAGES;
  // Operand/carry registers exist only between stages; keep one dummy slot when STAGES=1
  localparam int NOPS  = (STAGES > 1) ? STAGES - 1 : 1;

  logic              adv;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  opa_q [NOPS];
  logic [WIDTH-1:0]  opa_d [NOPS];
  logic [WIDTH-1:0]  opb_q [NOPS];
  logic [WIDTH-1:0]  opb_d [NOPS];
  logic [NOPS-1:0]   cy_q, cy_d;

  logic [WIDTH-1:0]  st_a [STAGES];
  logic [WIDTH-1:0]  st_b [STAGES];
  logic [STAGES-1:0] st_cin;
  logic [CHUNK-1:0]  ch_sum [STAGES];
  logic [STAGES-1:0] ch_cout;

`ifdef ADDER_FLAGS_EN
  logic [3:0] flags_q, flags_d;
`endif

  // Whole pipe moves together whenever the output slot is empty or being drained
  assign adv       = !vld_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign out       = res_q[STAGES-1];
`ifdef ADDER_FLAGS_EN
  assign flags     = flags_q;
`endif

  // Operands seen by each stage: stage 0 from the ports, later stages from the carried copies
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_a[k] = '0;
      st_b[k] = '0;
    end
    st_cin    = '0;
    st_a[0]   = a;
    st_b[0]   = sub ? ~b : b;
    st_cin[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = opa_q[k-1];
      st_b[k]   = opb_q[k-1];
      st_cin[k] = cy_q[k-1];
    end
  end

  // One CHUNK-wide adder per stage; its carry feeds the next stage one cycle later
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      {ch_cout[k], ch_sum[k]} = {1'b0, st_a[k][k*CHUNK +: CHUNK]}
                              + {1'b0, st_b[k][k*CHUNK +: CHUNK]}
                              + {{CHUNK{1'b0}}, st_cin[k]};
    end
  end

  // Next-state: hold everything on a stall, otherwise shift every stage by one
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    for (int k = 0; k < STAGES; k++) res_d[k] = res_q[k];
    for (int k = 0; k < NOPS; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
    end
`ifdef ADDER_FLAGS_EN
    flags_d = flags_q;
`endif
    if (adv) begin
      vld_d[0]             = in_valid;
      res_d[0]             = '0;
      res_d[0][CHUNK-1:0]  = ch_sum[0];
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]                  = vld_q[k-1];
        res_d[k]                  = res_q[k-1];
        res_d[k][k*CHUNK +: CHUNK] = ch_sum[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        opa_d[k] = st_a[k];
        opb_d[k] = st_b[k];
        cy_d[k]  = ch_cout[k];
      end
`ifdef ADDER_FLAGS_EN
      // N, Z, C, V registered with the final chunk so they stay aligned with out
      flags_d[3] = res_d[STAGES-1][WIDTH-1];
      flags_d[2] = (res_d[STAGES-1] == '0);
      flags_d[1] = ch_cout[STAGES-1];
      flags_d[0] = (st_a[STAGES-1][WIDTH-1] == st_b[STAGES-1][WIDTH-1]) &
                   (res_d[STAGES-1][WIDTH-1] != st_a[STAGES-1][WIDTH-1]);
`endif
    end
  end

  // Control and result registers; reset drops every in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
`ifdef ADDER_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) res_q[k] <= res_d[k];
`ifdef ADDER_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  // Carried operand chunks and inter-stage carries; qualified by the valid bits
  always_ff @(posedge clk) begin
    cy_q <= cy_d;
    for (int k = 0; k < NOPS; k++) begin
      opa_q[k] <= opa_d[k];
      opb_q[k] <= opb_d[k];
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe
module tb_adder_pipe;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
`ifdef ADDER_FLAGS_EN
  logic [3:0]       flags;
`endif

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out)
`ifdef ADDER_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH+3:0] exp_q[$];
  logic [WIDTH+3:0] sb_e;

  // Reference: plain wide arithmetic, {N,Z,C,V} above the result
  function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic ms);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    logic             n, z, c, v;
    be   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, ms};
    n    = full[WIDTH-1];
    z    = (full[WIDTH-1:0] == '0);
    c    = full[WIDTH];
    v    = (ma[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return {n, z, c, v, full[WIDTH-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out !== '0) begin n_fail++; $display("FAIL rst_out: got %h want 0", out); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
`ifdef ADDER_FLAGS_EN
    n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", flags); end
`endif
  endtask

  task automatic test_basic();
    int lat;
    tick();
    a = 64'd0; b = 64'd4; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    n_tests++; if (lat !== STAGES) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, STAGES); end
    n_tests++; if (out !== 64'h4) begin n_fail++; $display("FAIL basic_out: got %h want 4", out); end
`ifdef ADDER_FLAGS_EN
    n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b want 0000", flags); end
`endif
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_carry_flags();
    logic [WIDTH-1:0] ta [4];
    logic [WIDTH-1:0] tb [4];
    logic             ts [4];
    logic [WIDTH-1:0] to [4];
    logic [3:0]       tf [4];
    int               k;
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'h13; ts[0] = 1'b0; to[0] = 64'h12;                  tf[0] = 4'b0010;
    ta[1] = 64'h5;                   tb[1] = 64'h5;  ts[1] = 1'b1; to[1] = 64'h0;                   tf[1] = 4'b0110;
    ta[2] = 64'h0;                   tb[2] = 64'h1;  ts[2] = 1'b1; to[2] = 64'hFFFF_FFFF_FFFF_FFFF; tf[2] = 4'b1000;
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'h1;  ts[3] = 1'b0; to[3] = 64'h8000_0000_0000_0000; tf[3] = 4'b1001;
    tick();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          a = ta[i]; b = tb[i]; sub = ts[i]; in_valid = 1'b1;
          tick();
        end
        in_valid = 1'b0; sub = 1'b0;
      end
      begin
        k = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
          @(negedge clk);
          if (out_valid) begin
            n_tests++; if (out !== to[k]) begin n_fail++; $display("FAIL carry_out[%0d]: got %h want %h", k, out, to[k]); end
`ifdef ADDER_FLAGS_EN
            n_tests++; if (flags !== tf[k]) begin n_fail++; $display("FAIL carry_flags[%0d]: got %b want %b", k, flags, tf[k]); end
`endif
            k++;
          end
        end
        n_tests++; if (k !== 4) begin n_fail++; $display("FAIL carry_count: got %0d want 4", k); end
      end
    join
  endtask

  task automatic test_back_to_back();
    int               i, got, stalls;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_out;
    i = 0; got = 0; stalls = 0; prev_stall = 1'b0; prev_out = '0;
    tick();
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (i < 8);
      a = WIDTH'(i); b = WIDTH'(i); sub = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        n_tests++; if (out !== prev_out) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", out, prev_out); end
      end
      if (out_valid && !out_ready) begin
        stalls++;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
        prev_stall = 1'b1;
        prev_out   = out;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_tests++; if (out !== WIDTH'(2 * got)) begin n_fail++; $display("FAIL b2b_order: got %h want %h", out, WIDTH'(2 * got)); end
        got++;
      end
      if (in_valid && in_ready) i++;
      if (got == 8) break;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
    n_tests++; if (stalls !== 3) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 3", stalls); end
    repeat (STAGES + 2) @(negedge clk);
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'(i + 1); b = 64'h1; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (STAGES + 2) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped: out_valid seen %b want 0", seen); end
    tick();
    a = 64'd9; b = 64'd1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    n_tests++; if (lat !== STAGES) begin n_fail++; $display("FAIL rstmid_latency: got %0d want %0d", lat, STAGES); end
    n_tests++; if (out !== 64'd10) begin n_fail++; $display("FAIL rstmid_out: got %h want a", out); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    // Scoreboard: push on accept, pop and compare on delivery, flush on reset
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          exp_q.delete();
        end else begin
          if (out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL sb_unexpected: got out %h want no output", out);
            end else begin
              sb_e = exp_q.pop_front();
              if (out !== sb_e[WIDTH-1:0]) begin
                n_fail++; $display("FAIL sb_out: got %h want %h", out, sb_e[WIDTH-1:0]);
              end
`ifdef ADDER_FLAGS_EN
              n_tests++;
              if (flags !== sb_e[WIDTH+3:WIDTH]) begin
                n_fail++; $display("FAIL sb_flags: got %b want %b", flags, sb_e[WIDTH+3:WIDTH]);
              end
`endif
            end
          end
          if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
        end
      end
    join_none
    test_reset();
    test_basic();
    test_carry_flags();
    test_back_to_back();
    test_reset_mid();
    repeat (STAGES + 2) @(negedge clk);
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_drain: got %0d pending want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
